lcd_hd44780_ctrl: RTL and testbench
===================================

Name: lcd_hd44780_ctrl

Overview:
Character-LCD (HD44780, 16x2) controller fed by the 32-bit LCD PIO word that the PCIe host writes through the PCIe system core. After reset it runs the power-on wait and init sequence itself. It then converts each new host command word into a correctly timed RS/EN/DATA write cycle on the board LCD pins. A status word goes back to the host via an input PIO.

Parameters:
POWERON_CYC, 750000, clk cycles to wait after reset before init (15 ms at 50 MHz)
SETUP_CYC, 4, cycles RS/DATA are stable before EN rises
EN_CYC, 25, cycles EN is held high
HOLD_CYC, 4, cycles RS/DATA are held after EN falls
SHORT_WAIT_CYC, 2000, execution wait for normal commands and data (40 us)
LONG_WAIT_CYC, 82000, execution wait for clear/home (1.64 ms)

Ports:
clk_clk  in  1  system clock (50 MHz); same domain as the PIO
reset_reset_n  in  1  asynchronous active-low reset
cmd_word  in  32  host command: [7:0] data, [8] RS, [29] backlight, [30] overrun-clear (level), [31] toggle (a new command is signalled by a change)
lcd_data  out  8  LCD DB7..DB0
lcd_rs  out  1  register select
lcd_rw  out  1  read/write, tied 0 (write only)
lcd_en  out  1  enable strobe
lcd_on  out  1  LCD power
lcd_blon  out  1  backlight, registered copy of cmd_word[29]
status  out  32  [31] busy, [30] overrun, [29] pending, [28] init_done, [27:8] 0, [7:0] completed host command count

Behaviour:
- Reset values: all outputs 0; internal last_toggle=0; FSM=PWRON_WAIT. lcd_on goes to 1 on the first clock after reset deasserts.
- States:
  - PWRON_WAIT: count POWERON_CYC, then go to INIT.
  - INIT: issue the 4-entry ROM in order, each as a full write cycle with RS=0: 0x38, 0x0C, 0x01, 0x06.
  - SETUP: SETUP_CYC cycles.
  - EN_HIGH: EN_CYC cycles.
  - HOLD: HOLD_CYC cycles.
  - EXEC_WAIT: SHORT_WAIT_CYC or LONG_WAIT_CYC cycles.
  - After EXEC_WAIT: next INIT entry, then IDLE.
- One write cycle:
  - lcd_rs/lcd_data are loaded on entry to SETUP and held through HOLD.
  - lcd_en=1 only in EN_HIGH.
  - Total cycles = SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- Long wait applies when RS=0 and data is 0x01, 0x02 or 0x03; all other commands use the short wait.
- Toggle detect: every cycle, a new command is flagged when cmd_word[31] != last_toggle. On detection, last_toggle<=cmd_word[31] and {RS,data} are captured.
  - FSM in IDLE and pending empty: start SETUP next cycle (2-cycle latency from PIO change to lcd_rs/lcd_data update).
  - FSM busy (including PWRON_WAIT/INIT) and pending empty: store in the 1-deep pending buffer and set pending.
  - FSM busy and pending full: drop the new command and set overrun (sticky). The pending contents are kept.
- On return to IDLE with pending set: start the pending command the next cycle and clear pending.
- Simultaneous pending-issue and new detect in the same cycle: the new command goes into the freed pending slot, with no overrun.
- overrun clears while cmd_word[30]=1. A set and a clear in the same cycle: set wins.
- busy=1 in every state except IDLE.
- init_done is set when INIT completes and is cleared only by reset.
- status[7:0] increments at the end of EXEC_WAIT of each host command (init ROM entries not counted). Wraps 255->0.
- Reset mid-operation: outputs drop to 0 asynchronously, and the full power-on wait and init repeat. A pending command is discarded.
- lcd_blon follows cmd_word[29] with 1-cycle latency in all states.

Test Plan:
Shared parameters: POWERON_CYC=100, SETUP=2, EN=4, HOLD=2, SHORT=10, LONG=50.
- Reset release -> lcd_on=1 next cycle. After 100 cycles, four EN pulses each 4 cycles wide with lcd_data 0x38, 0x0C, 0x01, 0x06. The gap after 0x01 is 50 cycles. init_done=1 and busy=0 after the last wait.
- After init, write 0x8000_0141 (toggle=1, RS=1, 'A') -> lcd_rs=1 and lcd_data=0x41 two cycles later. EN high for exactly 4 cycles. busy for 18 cycles. status[7:0]=1.
- Command 0x0000_0001 (toggle back to 0, clear) -> EXEC_WAIT is 50 cycles. The count advances to 2 only after the long wait.
- Three toggles during one busy cycle (data 0x31, 0x32, 0x33) -> 0x31 executes, 0x32 is pending and executes next, 0x33 is dropped. overrun=1 until a word with bit30=1 arrives, then 0.
- Toggle during PWRON_WAIT -> the command is held in pending and issued immediately after the 0x06 init entry. Its count appears as 1.
- Assert reset_reset_n=0 during EN_HIGH -> lcd_en, lcd_data and status go to 0 immediately. After release, the full 100-cycle wait and init run again.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// ============================================================================
// Module   : lcd_hd44780_ctrl
// Purpose  : HD44780 16x2 character-LCD controller driven by a host PIO word.
//            Runs the power-on wait and the 4-entry init sequence by itself.
//            It then turns each toggled host command into one timed
//            RS/EN/DATA write cycle. A 1-deep pending buffer holds one command
//            that arrives while the controller is busy.
// Ports    : clk_clk        - system clock, same domain as the PIO
//            reset_reset_n  - asynchronous active-low reset
//            cmd_word       - [7:0] data, [8] RS, [29] backlight,
//                             [30] overrun clear (level), [31] toggle
//            lcd_data/rs/rw/en/on/blon - LCD pins
//            status         - [31] busy, [30] overrun, [29] pending,
//                             [28] init_done, [7:0] completed command count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_hd44780_ctrl #(
    parameter int POWERON_CYC    = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 25,
    parameter int HOLD_CYC       = 4,
    parameter int SHORT_WAIT_CYC = 2000,
    parameter int LONG_WAIT_CYC  = 82000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] cmd_word,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon,
    output logic [31:0] status
);

    localparam logic [31:0] PWR_LAST   = 32'(POWERON_CYC - 1);
    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
    localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] SHORT_LAST = 32'(SHORT_WAIT_CYC - 1);
    localparam logic [31:0] LONG_LAST  = 32'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        PWRON_WAIT = 3'd0,
        INIT       = 3'd1,
        IDLE       = 3'd2,
        SETUP      = 3'd3,
        EN_HIGH    = 3'd4,
        HOLD       = 3'd5,
        EXEC_WAIT  = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  init_idx;
    logic        in_init;
    logic        last_toggle;
    logic        start_req;      // command captured while idle, starts next cycle
    logic [8:0]  start_cmd;
    logic        pend_valid;     // command captured while busy
    logic [8:0]  pend_cmd;
    logic        overrun;
    logic        init_done;
    logic        busy;
    logic [7:0]  done_cnt;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    init_rom = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    init_rom = 8'h0C;   // display on, cursor off
            2'd2:    init_rom = 8'h01;   // clear display
            default: init_rom = 8'h06;   // entry mode: increment, no shift
        endcase
    endfunction

    logic       detect;
    logic [8:0] new_cmd;
    logic       issue_pend;
    logic       to_start;
    logic       slot_free;
    logic       drop;
    logic       long_wait;
    logic [31:0] wait_last;
    logic       unused_cmd_bits;

    assign detect     = cmd_word[31] != last_toggle;
    assign new_cmd    = cmd_word[8:0];
    assign issue_pend = (state == IDLE) && !start_req && pend_valid;
    assign to_start   = detect && (state == IDLE) && !start_req && !pend_valid;
    // The pending slot counts as free when it is being issued this very cycle.
    assign slot_free  = !pend_valid || issue_pend;
    assign drop       = detect && !to_start && !slot_free;
    // Clear and return-home style commands need the long execution time.
    assign long_wait  = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 ||
                                    lcd_data == 8'h03);
    assign wait_last  = long_wait ? LONG_LAST : SHORT_LAST;

    assign unused_cmd_bits = &{1'b0, cmd_word[28:9]};

    assign lcd_rw = 1'b0;
    assign status = {busy, overrun, pend_valid, init_done, 20'd0, done_cnt};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= PWRON_WAIT;
            cnt         <= '0;
            init_idx    <= '0;
            in_init     <= 1'b0;
            last_toggle <= 1'b0;
            start_req   <= 1'b0;
            start_cmd   <= '0;
            pend_valid  <= 1'b0;
            pend_cmd    <= '0;
            overrun     <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b0;
            done_cnt    <= '0;
            lcd_data    <= '0;
            lcd_rs      <= 1'b0;
            lcd_en      <= 1'b0;
            lcd_on      <= 1'b0;
            lcd_blon    <= 1'b0;
        end else begin
            lcd_on   <= 1'b1;
            lcd_blon <= cmd_word[29];

            // Host command intake
            if (detect) begin
                last_toggle <= cmd_word[31];
            end
            if (to_start) begin
                start_req <= 1'b1;
                start_cmd <= new_cmd;
            end
            if (issue_pend) begin
                pend_valid <= 1'b0;
            end
            if (detect && !to_start && slot_free) begin
                pend_valid <= 1'b1;
                pend_cmd   <= new_cmd;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (cmd_word[30]) begin
                overrun <= 1'b0;
            end

            case (state)
                PWRON_WAIT: begin
                    busy <= 1'b1;
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT: begin
                    in_init  <= 1'b1;
                    init_idx <= 2'd0;
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_rom(2'd0);
                    state    <= SETUP;
                end
                IDLE: begin
                    if (start_req) begin
                        start_req          <= 1'b0;
                        {lcd_rs, lcd_data} <= start_cmd;
                        busy               <= 1'b1;
                        state              <= SETUP;
                    end else if (pend_valid) begin
                        {lcd_rs, lcd_data} <= pend_cmd;
                        busy               <= 1'b1;
                        state              <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b1;
                        state  <= EN_HIGH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EN_HIGH: begin
                    if (cnt == EN_LAST) begin
                        cnt    <= '0;
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= EXEC_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EXEC_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (in_init) begin
                            if (init_idx == 2'd3) begin
                                in_init   <= 1'b0;
                                init_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                lcd_rs   <= 1'b0;
                                lcd_data <= init_rom(init_idx + 2'd1);
                                state    <= SETUP;
                            end
                        end else begin
                            done_cnt <= done_cnt + 8'd1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_ctrl.sv
// ============================================================================
// Module   : tb_lcd_hd44780_ctrl
// Purpose  : Self-checking bench for lcd_hd44780_ctrl. Expected LCD write
//            cycles are queued when commands are driven; a monitor records
//            every EN pulse and the two are compared in order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_hd44780_ctrl;

    localparam int PWR = 100;
    localparam int SU  = 2;
    localparam int ENC = 4;
    localparam int HO  = 2;
    localparam int SH  = 10;
    localparam int LG  = 50;

    localparam int GAP_CHAIN = HO + SH + SU;        // short wait, next entry directly
    localparam int GAP_LONG  = HO + LG + SU;        // long wait, next entry directly
    localparam int GAP_IDLE  = HO + SH + 1 + SU;    // short wait, one IDLE cycle between

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] cmd_word = 32'd0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [31:0] status;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl #(
        .POWERON_CYC(PWR), .SETUP_CYC(SU), .EN_CYC(ENC), .HOLD_CYC(HO),
        .SHORT_WAIT_CYC(SH), .LONG_WAIT_CYC(LG)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .cmd_word(cmd_word),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon), .status(status)
    );

    typedef struct { logic [8:0] cmd; int gap; } exp_t;
    typedef struct { logic [8:0] cmd; int width; int gap; int rise; } obs_t;
    typedef struct { logic rs; logic [7:0] data; logic blon; int busy_len; } vec_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    vec_t vecs[8];

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       toggle = 1'b0;
    logic [7:0] exp_count = 8'd0;

    // EN pulse monitor
    logic en_prev = 1'b0;
    int   width = 0;
    int   last_fall = 0;
    obs_t cur;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            en_prev = 1'b0;
            width   = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                cur.cmd  = {lcd_rs, lcd_data};
                cur.rise = cyc;
                cur.gap  = cyc - last_fall;
                width    = 1;
            end else if (lcd_en) begin
                width = width + 1;
            end else if (en_prev) begin
                cur.width = width;
                last_fall = cyc;
                obs_q.push_back(cur);
            end
            en_prev = lcd_en;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input logic blon);
        toggle   = ~toggle;
        cmd_word = {toggle, 1'b0, blon, 20'd0, rs, data};
    endtask

    task automatic push_exp(input logic [8:0] cmd, input int gap);
        exp_t e;
        e.cmd = cmd;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push_exp({1'b0, 8'h38}, -1);
        push_exp({1'b0, 8'h0C}, GAP_CHAIN);
        push_exp({1'b0, 8'h01}, GAP_CHAIN);
        push_exp({1'b0, 8'h06}, GAP_LONG);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        obs_t o;
        int   guard;
        guard = 0;
        while (exp_q.size() > 0) begin
            while (obs_q.size() == 0 && guard < 400) begin
                tick();
                guard = guard + 1;
            end
            if (obs_q.size() == 0) begin
                timeout({tag, " pulse missing"});
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                check({tag, " rs/data"}, int'(o.cmd), int'(e.cmd));
                check({tag, " en width"}, o.width, ENC);
                if (e.gap >= 0) check({tag, " gap"}, o.gap, e.gap);
            end
        end
        check({tag, " extra pulses"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        while ((status[31] || status[29]) && g < 1000) begin
            tick();
            g = g + 1;
        end
        if (status[31] || status[29]) timeout({tag, " idle"});
    endtask

    // Resets the DUT after the reset pin was already driven low, then checks
    // the power-on wait, the init sequence and the state after init.
    task automatic powerup(input string tag, input logic with_pending);
        int rel;
        int g;
        push_init();
        repeat (3) tick();
        rst_n = 1'b1;
        rel = cyc;
        tick();
        check({tag, " lcd_on after release"}, int'(lcd_on), 1);
        check({tag, " busy after release"}, int'(status[31]), 1);
        if (with_pending) begin
            repeat (20) tick();
            send(1'b1, 8'h55, 1'b0);
            push_exp({1'b1, 8'h55}, GAP_IDLE);
            tick();
            tick();
            check({tag, " pending during poweron"}, int'(status[29]), 1);
            check({tag, " en quiet during poweron"}, int'(lcd_en), 0);
        end
        g = 0;
        while (obs_q.size() == 0 && g < 300) begin
            tick();
            g = g + 1;
        end
        if (obs_q.size() == 0) timeout({tag, " first EN"});
        else check({tag, " poweron wait"},
                   int'((obs_q[0].rise - rel) >= PWR + 1 && (obs_q[0].rise - rel) <= PWR + 6), 1);
        g = 0;
        while (!status[28] && g < 1000) begin
            tick();
            g = g + 1;
        end
        if (!status[28]) timeout({tag, " init_done"});
        check({tag, " busy at init_done"}, int'(status[31]), 0);
        check({tag, " pending at init_done"}, int'(status[29]), int'(with_pending));
        check({tag, " count at init_done"}, int'(status[7:0]), 0);
        wait_idle(tag);
        if (with_pending) exp_count = exp_count + 8'd1;
        check({tag, " count after init"}, int'(status[7:0]), int'(exp_count));
        check({tag, " overrun after init"}, int'(status[30]), 0);
        drain(tag);
    endtask

    initial begin
        int len;
        int pre;
        int g;

        vecs[0] = '{1'b1, 8'h41, 1'b0, SU + ENC + HO + SH};
        vecs[1] = '{1'b0, 8'h01, 1'b0, SU + ENC + HO + LG};
        vecs[2] = '{1'b0, 8'h02, 1'b1, SU + ENC + HO + LG};
        vecs[3] = '{1'b0, 8'h03, 1'b0, SU + ENC + HO + LG};
        vecs[4] = '{1'b0, 8'h04, 1'b0, SU + ENC + HO + SH};
        vecs[5] = '{1'b0, 8'h00, 1'b1, SU + ENC + HO + SH};
        vecs[6] = '{1'b1, 8'h01, 1'b0, SU + ENC + HO + SH};
        vecs[7] = '{1'b0, 8'h80, 1'b1, SU + ENC + HO + SH};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset lcd_on", int'(lcd_on), 0);
        check("reset lcd_en", int'(lcd_en), 0);
        check("reset lcd_data", int'(lcd_data), 0);
        check("reset lcd_rw", int'(lcd_rw), 0);
        check("reset status", int'(status), 0);

        // Power-on with a command arriving during the power-on wait
        powerup("init", 1'b1);

        // Table of single commands
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].rs, vecs[i].data, vecs[i].blon);
            push_exp({vecs[i].rs, vecs[i].data}, -1);
            tick();
            check("vec busy before start", int'(status[31]), 0);
            check("vec blon", int'(lcd_blon), int'(vecs[i].blon));
            tick();
            check("vec rs/data latency", int'({lcd_rs, lcd_data}), int'({vecs[i].rs, vecs[i].data}));
            len = 0;
            pre = int'(status[7:0]);
            while (status[31] && len < 300) begin
                pre = int'(status[7:0]);
                len = len + 1;
                tick();
            end
            check("vec busy length", len, vecs[i].busy_len);
            check("vec count before end", pre, int'(exp_count));
            exp_count = exp_count + 8'd1;
            check("vec count after", int'(status[7:0]), int'(exp_count));
            drain("vec");
        end

        // Three commands inside one busy period: one runs, one pends, one drops
        send(1'b1, 8'h31, 1'b0);
        push_exp({1'b1, 8'h31}, -1);
        repeat (3) tick();
        send(1'b1, 8'h32, 1'b0);
        push_exp({1'b1, 8'h32}, GAP_IDLE);
        tick();
        check("ovr pending set", int'(status[29]), 1);
        check("ovr not yet", int'(status[30]), 0);
        tick();
        send(1'b1, 8'h33, 1'b0);
        tick();
        check("ovr set", int'(status[30]), 1);
        check("ovr pending kept", int'(status[29]), 1);
        wait_idle("ovr");
        exp_count = exp_count + 8'd2;
        check("ovr count", int'(status[7:0]), int'(exp_count));
        check("ovr sticky", int'(status[30]), 1);
        drain("ovr");
        cmd_word[30] = 1'b1;
        tick();
        check("ovr cleared", int'(status[30]), 0);
        cmd_word[30] = 1'b0;
        tick();

        // Reset in the middle of an EN pulse
        send(1'b1, 8'h41, 1'b0);
        g = 0;
        while (!lcd_en && g < 50) begin
            tick();
            g = g + 1;
        end
        if (!lcd_en) timeout("midrst en");
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst lcd_en", int'(lcd_en), 0);
        check("midrst lcd_data", int'(lcd_data), 0);
        check("midrst status", int'(status), 0);
        cmd_word  = 32'd0;
        toggle    = 1'b0;
        exp_count = 8'd0;
        exp_q.delete();
        obs_q.delete();
        tick();
        powerup("midrst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
